// File: rtl/testpattern_gen_pkg.sv
// Shared definitions for the video timing / test-pattern generator:
// pattern encodings, default 480p timing and the default noise tap mask.
package testpattern_gen_pkg;

   typedef enum logic [1:0] {
      PAT_CHECKER = 2'd0,
      PAT_BARS    = 2'd1,
      PAT_RAMP    = 2'd2,
      PAT_NOISE   = 2'd3
   } pat_e;

   // 720x480 progressive at 27 MHz
   localparam int DEF_H_SYNCLEN   = 62;
   localparam int DEF_H_BACKPORCH = 60;
   localparam int DEF_H_ACTIVE    = 720;
   localparam int DEF_H_TOTAL     = 858;
   localparam int DEF_V_SYNCLEN   = 6;
   localparam int DEF_V_BACKPORCH = 30;
   localparam int DEF_V_ACTIVE    = 480;
   localparam int DEF_V_TOTAL     = 525;

   localparam int          DEF_LFSR_W    = 16;
   localparam logic [15:0] DEF_LFSR_TAPS = 16'hD008;

   // Bar index 0..7 -> white, yellow, cyan, green, magenta, red, blue, black
   function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
      return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
   endfunction

endpackage

// File: rtl/testpattern_gen_lfsr.sv
// Left-shifting Fibonacci LFSR with loadable seed. The register never holds
// zero: a zero seed or a zero next state is replaced by 1.
module tpg_lfsr
   import testpattern_gen_pkg::*;
#(
   parameter int           W    = DEF_LFSR_W,
   parameter logic [W-1:0] TAPS = W'(DEF_LFSR_TAPS)
) (
   input  logic         clk27,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] seed,
   input  logic         step,
   output logic [W-1:0] q
);

   logic [W-1:0] q_nx;

   // next state: shift left, feedback = XOR of tapped bits into bit 0
   always_comb begin
      q_nx = {q[W-2:0], ^(q & TAPS)};
   end

   // load has priority over step; zero is never stored
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         q <= W'(1);
      end else if (load) begin
         q <= (seed == '0) ? W'(1) : seed;
      end else if (step) begin
         q <= (q_nx == '0) ? W'(1) : q_nx;
      end
   end

endmodule

// File: rtl/testpattern_gen.sv
// Video timing and test-pattern generator (checker, colour bars, grey ramp,
// LFSR noise). All video outputs are registered one clk27 after the h/v
// counter state they describe.
// Build option: TPG_NOISE_SCROLL_EN adds a frame-seed LFSR so the noise
// field changes every frame; without it the noise restarts from 1 each frame.
module testpattern_gen
   import testpattern_gen_pkg::*;
#(
   parameter int                H_SYNCLEN   = DEF_H_SYNCLEN,
   parameter int                H_BACKPORCH = DEF_H_BACKPORCH,
   parameter int                H_ACTIVE    = DEF_H_ACTIVE,
   parameter int                H_TOTAL     = DEF_H_TOTAL,
   parameter int                V_SYNCLEN   = DEF_V_SYNCLEN,
   parameter int                V_BACKPORCH = DEF_V_BACKPORCH,
   parameter int                V_ACTIVE    = DEF_V_ACTIVE,
   parameter int                V_TOTAL     = DEF_V_TOTAL,
   parameter logic              HS_POL      = 1'b0,
   parameter logic              VS_POL      = 1'b0,
   parameter int                CNT_W       = 11,
   parameter int                LFSR_W      = DEF_LFSR_W,
   parameter logic [LFSR_W-1:0] LFSR_TAPS   = LFSR_W'(DEF_LFSR_TAPS),
   parameter int                RAMP_STEP   = 2
) (
   input  logic       clk27,
   input  logic       reset_n,
   input  logic [1:0] pat_sel,
   output logic [7:0] R_out,
   output logic [7:0] G_out,
   output logic [7:0] B_out,
   output logic       HSYNC_out,
   output logic       VSYNC_out,
   output logic       ENABLE_out,
   output logic       PCLK_out,
   output logic       frame_start
);

   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNCLEN);
   localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNCLEN);
   localparam logic [CNT_W-1:0] X_START   = CNT_W'(H_SYNCLEN + H_BACKPORCH);
   localparam logic [CNT_W-1:0] X_END     = CNT_W'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
   localparam logic [CNT_W-1:0] Y_START   = CNT_W'(V_SYNCLEN + V_BACKPORCH);
   localparam logic [CNT_W-1:0] Y_END     = CNT_W'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
   localparam logic [CNT_W-1:0] BAR_LAST  = CNT_W'(BAR_W - 1);
   localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'((RAMP_STEP > 0) ? RAMP_STEP - 1 : 0);

   logic [CNT_W-1:0]  h_cnt;
   logic [CNT_W-1:0]  v_cnt;
   logic              line_end;
   logic              frame_end;
   logic              h_act;
   logic              v_act;
   logic              act;

   pat_e              pat_q;

   logic [CNT_W-1:0]  bar_px;
   logic [2:0]        bar_idx;
   logic [CNT_W-1:0]  ramp_ph;
   logic [7:0]        ramp_val;

   logic [LFSR_W-1:0] pix_lfsr;
   logic [LFSR_W-1:0] pix_seed;
   logic              pix_step;

   logic [23:0]       pix;
   logic              fs_pend;

   assign line_end  = (h_cnt == H_LAST);
   assign frame_end = line_end && (v_cnt == V_LAST);
   assign h_act     = (h_cnt >= X_START) && (h_cnt < X_END);
   assign v_act     = (v_cnt >= Y_START) && (v_cnt < Y_END);
   assign act       = h_act && v_act;
   assign pix_step  = act && (pat_q == PAT_NOISE);

   assign PCLK_out  = clk27;

   // raster position: h wraps every line, v advances at line end
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (line_end) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // pattern select only takes effect on a frame boundary
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         pat_q <= PAT_CHECKER;
      end else if (frame_end) begin
         pat_q <= pat_e'(pat_sel);
      end
   end

   // bar position: pixel-in-bar counter and bar index, held at bar 7 past the last full bar
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (!act) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (bar_idx != 3'd7) begin
         if (bar_px == BAR_LAST) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_px  <= bar_px + 1'b1;
         end
      end
   end

   // grey ramp: level advances every RAMP_STEP active pixels, restarts each line
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         ramp_ph  <= '0;
         ramp_val <= '0;
      end else if (!act) begin
         ramp_ph  <= '0;
         ramp_val <= '0;
      end else if (ramp_ph == RAMP_LAST) begin
         ramp_ph  <= '0;
         ramp_val <= ramp_val + 8'd1;
      end else begin
         ramp_ph  <= ramp_ph + 1'b1;
      end
   end

`ifdef TPG_NOISE_SCROLL_EN
   logic [LFSR_W-1:0] seed_q;

   tpg_lfsr #(
      .W    (LFSR_W),
      .TAPS (LFSR_TAPS)
   ) u_seed_lfsr (
      .clk27   (clk27),
      .reset_n (reset_n),
      .load    (1'b0),
      .seed    ({LFSR_W{1'b0}}),
      .step    (frame_end),
      .q       (seed_q)
   );

   // the pixel LFSR takes the seed LFSR's next state, so both agree for the new frame
   always_comb begin
      pix_seed = {seed_q[LFSR_W-2:0], ^(seed_q & LFSR_TAPS)};
      if (pix_seed == '0) begin
         pix_seed = LFSR_W'(1);
      end
   end
`else
   assign pix_seed = LFSR_W'(1);
`endif

   tpg_lfsr #(
      .W    (LFSR_W),
      .TAPS (LFSR_TAPS)
   ) u_pix_lfsr (
      .clk27   (clk27),
      .reset_n (reset_n),
      .load    (frame_end),
      .seed    (pix_seed),
      .step    (pix_step),
      .q       (pix_lfsr)
   );

   // pixel colour for the current raster position; black outside the active area
   always_comb begin
      pix = '0;
      if (act) begin
         unique case (pat_q)
            PAT_CHECKER: pix = (h_cnt[0] ^ v_cnt[0]) ? 24'hFFFFFF : 24'h000000;
            PAT_BARS:    pix = bar_rgb(bar_idx);
            PAT_RAMP:    pix = {3{ramp_val}};
            PAT_NOISE:   pix = (pix_lfsr[LFSR_W-1 -: 4] == 4'hF) ? 24'hCFCFCF : 24'h000000;
         endcase
      end
   end

   // registered video outputs; frame_start is delayed twice so it lines up with the first sync output
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         R_out       <= '0;
         G_out       <= '0;
         B_out       <= '0;
         ENABLE_out  <= 1'b0;
         HSYNC_out   <= HS_POL;
         VSYNC_out   <= VS_POL;
         fs_pend     <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         {R_out, G_out, B_out} <= pix;
         ENABLE_out  <= act;
         HSYNC_out   <= (h_cnt < H_SYNC_C) ? HS_POL : ~HS_POL;
         VSYNC_out   <= (v_cnt < V_SYNC_C) ? VS_POL : ~VS_POL;
         fs_pend     <= frame_end;
         frame_start <= fs_pend;
      end
   end

endmodule

// File: tb/tb_testpattern_gen.sv
// Directed bench for testpattern_gen using full-width lines (858 px) and a
// shortened 10-line frame so several frames fit in a short run.
module tb_testpattern_gen;

   localparam int HS_L = 62, HB = 60, HA = 720, HT = 858;
   localparam int VS_L = 2,  VB = 2,  VA = 4,   VT = 10;
   localparam int XS = HS_L + HB;
   localparam int YS = VS_L + VB;
   localparam int FRAME = HT * VT;
   localparam int NACT = HA * VA;

   logic       clk27 = 1'b0;
   logic       reset_n;
   logic [1:0] pat_sel;
   logic [7:0] r, g, b;
   logic       hs, vs, en, pclk, fs;
   wire [23:0] rgb = {r, g, b};

   int total = 0;
   int bad   = 0;
   int p;

   logic [23:0] fa [0:NACT-1];
   logic [23:0] fb [0:NACT-1];

   always #5 clk27 = ~clk27;

   testpattern_gen #(
      .H_SYNCLEN   (HS_L),
      .H_BACKPORCH (HB),
      .H_ACTIVE    (HA),
      .H_TOTAL     (HT),
      .V_SYNCLEN   (VS_L),
      .V_BACKPORCH (VB),
      .V_ACTIVE    (VA),
      .V_TOTAL     (VT),
      .HS_POL      (1'b0),
      .VS_POL      (1'b0),
      .CNT_W       (11),
      .LFSR_W      (16),
      .LFSR_TAPS   (16'hD008),
      .RAMP_STEP   (2)
   ) dut (
      .clk27       (clk27),
      .reset_n     (reset_n),
      .pat_sel     (pat_sel),
      .R_out       (r),
      .G_out       (g),
      .B_out       (b),
      .HSYNC_out   (hs),
      .VSYNC_out   (vs),
      .ENABLE_out  (en),
      .PCLK_out    (pclk),
      .frame_start (fs)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_nx(input logic [15:0] v);
      logic [15:0] n;
      n = {v[14:0], ^(v & 16'hD008)};
      if (n == 16'h0) n = 16'h1;
      return n;
   endfunction

   function automatic bit in_act(input int h, input int v);
      return (h >= XS) && (h < XS + HA) && (v >= YS) && (v < YS + VA);
   endfunction

   // outputs after each edge describe raster position p
   task automatic tick();
      @(posedge clk27);
      #1;
      p = (p + 1) % FRAME;
   endtask

   initial begin
      int h, v, idx, diff;
      int hs_low, vs_low, en_hi, fs_cnt, pix_err, nz_err, cf;
      logic [23:0] exp;
      logic [15:0] ml;

      reset_n = 1'b1;
      pat_sel = 2'd0;
      #2 reset_n = 1'b0;
      #1;
      check_val("rst_rgb", rgb, 24'h0);
      check_val("rst_en", en, 1'b0);
      check_val("rst_hs", hs, 1'b0);
      check_val("rst_vs", vs, 1'b0);
      check_val("rst_fs", fs, 1'b0);
      repeat (2) @(posedge clk27);
      @(negedge clk27);
      reset_n = 1'b1;
      p = FRAME - 1;

      // frame 0: checker, timing counts, pat_sel moved to bars mid-frame
      hs_low = 0; vs_low = 0; en_hi = 0; fs_cnt = 0; pix_err = 0;
      for (int i = 0; i < FRAME; i++) begin
         tick();
         h = p % HT;
         v = p / HT;
         if (hs == 1'b0) hs_low++;
         if (vs == 1'b0) vs_low++;
         if (en) en_hi++;
         if (fs) fs_cnt++;
         exp = !in_act(h, v) ? 24'h0 : (((h ^ v) & 1) != 0 ? 24'hFFFFFF : 24'h0);
         if (rgb !== exp || en !== in_act(h, v)) pix_err++;
         if (h == XS && v == YS)     check_val("chk_first", rgb, 24'h000000);
         if (h == XS + 1 && v == YS) check_val("chk_second", rgb, 24'hFFFFFF);
         if (p == 0) check_val("pclk", pclk, 1'b1);
         if (p == 4000) pat_sel = 2'd1;
      end
      check_val("hs_low_cycles", hs_low, 62 * VT);
      check_val("vs_low_cycles", vs_low, VS_L * HT);
      check_val("en_cycles", en_hi, NACT);
      check_val("fs_frame0", fs_cnt, 0);
      check_val("checker_pixels", pix_err, 0);

      // frame 1: colour bars
      fs_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         tick();
         h = p % HT;
         v = p / HT;
         if (fs) fs_cnt++;
         if (p == 0) check_val("fs_frame1", fs, 1'b1);
         if (v == YS) begin
            if (h == XS - 1)   check_val("bar_pre_en", en, 1'b0);
            if (h == XS)       check_val("bar_white", rgb, 24'hFFFFFF);
            if (h == XS + 89)  check_val("bar_white_end", rgb, 24'hFFFFFF);
            if (h == XS + 90)  check_val("bar_yellow", rgb, 24'hFFFF00);
            if (h == XS + 180) check_val("bar_cyan", rgb, 24'h00FFFF);
            if (h == XS + 629) check_val("bar_blue", rgb, 24'h0000FF);
            if (h == XS + 630) check_val("bar_black", rgb, 24'h000000);
            if (h == XS + 719) check_val("bar_last_en", en, 1'b1);
            if (h == XS + 720) check_val("bar_post_en", en, 1'b0);
         end
         if (v == YS + 3 && h == XS + 90) check_val("bar_line3_yellow", rgb, 24'hFFFF00);
         if (p == 4000) pat_sel = 2'd2;
      end
      check_val("fs_frame1_count", fs_cnt, 1);

      // frame 2: grey ramp
      for (int i = 0; i < FRAME; i++) begin
         tick();
         h = p % HT;
         v = p / HT;
         if (v == YS) begin
            if (h == XS)       check_val("ramp_px0", rgb, 24'h000000);
            if (h == XS + 1)   check_val("ramp_px1", rgb, 24'h000000);
            if (h == XS + 2)   check_val("ramp_px2", rgb, 24'h010101);
            if (h == XS + 3)   check_val("ramp_px3", rgb, 24'h010101);
            if (h == XS + 511) check_val("ramp_px511", rgb, 24'hFFFFFF);
            if (h == XS + 512) check_val("ramp_px512", rgb, 24'h000000);
            if (h == XS + 514) check_val("ramp_px514", rgb, 24'h010101);
         end
         if (v == YS + 1 && h == XS)     check_val("ramp_line1_px0", rgb, 24'h000000);
         if (v == YS + 1 && h == XS + 2) check_val("ramp_line1_px2", rgb, 24'h010101);
         if (p == 4000) pat_sel = 2'd3;
      end

      // frames 3 and 4: noise against a reference LFSR
      for (int fn = 3; fn <= 4; fn++) begin
         ml = 16'h0001;
`ifdef TPG_NOISE_SCROLL_EN
         for (int s = 0; s < fn; s++) ml = lfsr_nx(ml);
`endif
         idx = 0; nz_err = 0; cf = 0;
         for (int i = 0; i < FRAME; i++) begin
            tick();
            h = p % HT;
            v = p / HT;
            if (in_act(h, v)) begin
               exp = (ml[15:12] == 4'hF) ? 24'hCFCFCF : 24'h000000;
               if (rgb !== exp) nz_err++;
               if (rgb == 24'hCFCFCF) cf++;
               if (fn == 3) fa[idx] = rgb;
               else         fb[idx] = rgb;
               idx++;
               ml = lfsr_nx(ml);
            end else if (rgb !== 24'h0) begin
               nz_err++;
            end
         end
         check_val(fn == 3 ? "noise_model_f3" : "noise_model_f4", nz_err, 0);
         check_val(fn == 3 ? "noise_has_cf_f3" : "noise_has_cf_f4", (cf != 0), 1'b1);
      end
      diff = 0;
      for (int i = 0; i < NACT; i++) if (fa[i] !== fb[i]) diff++;
`ifdef TPG_NOISE_SCROLL_EN
      check_val("noise_frames_differ", (diff != 0), 1'b1);
`else
      check_val("noise_frames_equal", diff, 0);
`endif

      // frame 5: asynchronous reset in the middle of an active line
      for (int i = 0; i < FRAME && p != 5 * HT + 300; i++) tick();
      #2 reset_n = 1'b0;
      #1;
      check_val("mid_rst_rgb", rgb, 24'h0);
      check_val("mid_rst_en", en, 1'b0);
      check_val("mid_rst_hs", hs, 1'b0);
      check_val("mid_rst_vs", vs, 1'b0);
      check_val("mid_rst_fs", fs, 1'b0);
      @(posedge clk27);
      #1;
      check_val("mid_rst_hold_hs", hs, 1'b0);
      @(negedge clk27);
      reset_n = 1'b1;
      p = FRAME - 1;

      fs_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         tick();
         h = p % HT;
         v = p / HT;
         if (fs) fs_cnt++;
         if (p == 0) begin
            check_val("post_rst_hs0", hs, 1'b0);
            check_val("post_rst_vs0", vs, 1'b0);
         end
         if (p == 61)         check_val("post_rst_hs61", hs, 1'b0);
         if (p == 62)         check_val("post_rst_hs62", hs, 1'b1);
         if (p == 2 * HT - 1) check_val("post_rst_vs_last", vs, 1'b0);
         if (p == 2 * HT)     check_val("post_rst_vs_end", vs, 1'b1);
         if (h == XS + 1 && v == YS) check_val("post_rst_checker", rgb, 24'hFFFFFF);
      end
      check_val("post_rst_fs_unflagged", fs_cnt, 0);
      tick();
      check_val("post_rst_fs_pulse", fs, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
